sync_fifo_counter: RTL and testbench
====================================

Name:
sync_fifo_counter

Overview:
- Single-clock synchronous FIFO with an occupancy counter.
- Buffers DATA_WIDTH-bit words between a producer and a consumer in the same clock domain.
- Derives full/empty from an explicit occupancy count, which is also exported as fifo_cnt.
- The read data output is registered.

Parameters:
- DATA_WIDTH, 8: width of each stored word in bits.
- DATA_DEPTH, 8: number of storage entries; must be a power of 2, ≥2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- buf_in  input  DATA_WIDTH  write data, sampled on the rising edge when a write is accepted.
- buf_out  output  DATA_WIDTH  registered read data.
- empty  output  1  high when fifo_cnt == 0.
- full  output  1  high when fifo_cnt == DATA_DEPTH.
- fifo_cnt  output  clog2(DATA_DEPTH)+1  current occupancy, range 0..DATA_DEPTH.

Behaviour:
- Interface convention: one clock, clk; reset is asynchronous and active-high, port rst.
- Reset (rst=1, asynchronous assert, released synchronously by the system):
  - fifo_cnt=0, write pointer=0, read pointer=0, buf_out=0.
  - Consequently empty=1, full=0.
  - Storage contents need not be cleared.
- Accept conditions:
  - write accepted = wr_en & ~full.
  - read accepted = rd_en & ~empty.
  - Both flags are evaluated from pre-edge state.
- Accepted write: mem[wr_ptr] <= buf_in; wr_ptr increments modulo DATA_DEPTH.
- Accepted read: buf_out <= mem[rd_ptr]; rd_ptr increments modulo DATA_DEPTH.
  - Latency: data is valid on buf_out after the same edge that accepts the read (one cycle after rd_en is presented).
- buf_out holds its last value when no read is accepted, including reads attempted while empty.
- Counter update:
  - write only: +1.
  - read only: −1.
  - both or neither: unchanged.
- empty and full are combinational decodes of fifo_cnt; no registered lag.
- Boundary cases:
  - Write while full (no read): ignored; contents, pointers and count unchanged.
  - Read while empty: ignored; buf_out holds, count stays 0.
  - wr_en & rd_en while full: only the read is accepted; count becomes DATA_DEPTH−1; the write is dropped.
  - wr_en & rd_en while empty: only the write is accepted; count becomes 1; buf_out holds.
  - wr_en & rd_en with 0 < count < DEPTH: both accepted; count constant; data order preserved.
  - Pointer wrap: DEPTH−1 → 0 with no gap; FIFO order is preserved across the wrap.
  - Reset mid-operation: immediately returns to the reset state; in-flight data is discarded.
- Count never exceeds DATA_DEPTH and never underflows below 0.

Test Plan:
- Reset: assert rst → fifo_cnt=0, empty=1, full=0, buf_out=0.
- Fill: 8 consecutive writes of D0..D7 → fifo_cnt steps 1..8; full=1 after the 8th edge; empty=0 after the 1st edge.
  - A 9th write with wr_en=1 → fifo_cnt stays 8; contents unchanged.
- Drain: 8 consecutive reads → buf_out=D0..D7 in order, each one edge after its read; fifo_cnt 7..0; empty=1 at the end.
  - An extra read → buf_out holds D7; fifo_cnt stays 0.
- Partial fill and streaming: 4 writes (fifo_cnt=4), then continuous wr_en=rd_en=1 with random data → fifo_cnt stays 4 and full/empty stay 0.
  - buf_out reproduces the write stream delayed by 4 accepted entries, across pointer wrap.
- Simultaneous at the extremes:
  - Full with wr&rd → fifo_cnt 8→7; the oldest word appears on buf_out; the new word is not stored.
  - Empty with wr&rd → fifo_cnt 0→1; buf_out unchanged.
- Asynchronous reset mid-stream: assert rst between clock edges with fifo_cnt=5 → outputs return to reset values without waiting for a clk edge; subsequent writes start at entry 0.

Source files
------------

// File: rtl/sync_fifo_counter.sv
// sync_fifo_counter: single-clock FIFO with occupancy count and registered read data
module sync_fifo_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         buf_in,
  output logic [DATA_WIDTH-1:0]         buf_out,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(DATA_DEPTH):0]   fifo_cnt
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_buf_out;
  logic                  w_wr;
  logic                  w_rd;
  assign empty    = r_cnt == '0;
  assign full     = r_cnt == CW'(DATA_DEPTH);
  assign w_wr     = wr_en & ~full;
  assign w_rd     = rd_en & ~empty;
  assign fifo_cnt = r_cnt;
  assign buf_out  = r_buf_out;
  // storage is never reset; only accepted writes touch it
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= buf_in;
  end
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end
  // occupancy: +1 on write, -1 on read, unchanged when both or neither
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
  end
  // read data is registered and holds when no read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_buf_out <= '0;
    else if (w_rd) r_buf_out <= r_mem[r_rd_ptr];
  end
endmodule

// File: tb/tb_sync_fifo_counter.sv
// tb_sync_fifo_counter: directed self-checking bench for sync_fifo_counter
module tb_sync_fifo_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] buf_in = '0;
  logic [7:0] buf_out;
  logic       empty;
  logic       full;
  logic [3:0] fifo_cnt;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic [7:0] d;

  sync_fifo_counter #(.DATA_WIDTH(8), .DATA_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .buf_in(buf_in),
    .buf_out(buf_out), .empty(empty), .full(full), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] din);
    wr_en  = w;
    rd_en  = r;
    buf_in = din;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(fifo_cnt), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_out", 32'(buf_out), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'(8'hA0 + i));
      chk("fill_cnt", 32'(fifo_cnt), 32'(i + 1));
      chk("fill_empty", 32'(empty), 0);
      chk("fill_full", 32'(full), 32'(i == 7));
    end
    step(1, 0, 8'hFF);
    chk("ovf_cnt", 32'(fifo_cnt), 8);
    chk("ovf_full", 32'(full), 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'h00);
      chk("drain_out", 32'(buf_out), 32'(8'hA0 + i));
      chk("drain_cnt", 32'(fifo_cnt), 32'(7 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    step(0, 1, 8'h00);
    chk("udf_out", 32'(buf_out), 32'hA7);
    chk("udf_cnt", 32'(fifo_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'hB0 + i);
      q.push_back(d);
      step(1, 0, d);
    end
    chk("part_cnt", 32'(fifo_cnt), 4);
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      exp_d = q.pop_front();
      q.push_back(d);
      step(1, 1, d);
      chk("stream_out", 32'(buf_out), 32'(exp_d));
      chk("stream_cnt", 32'(fifo_cnt), 4);
      chk("stream_full", 32'(full), 0);
      chk("stream_empty", 32'(empty), 0);
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'hC0 + i);
      q.push_back(d);
      step(1, 0, d);
    end
    chk("refill_full", 32'(full), 1);
    exp_d = q.pop_front();
    step(1, 1, 8'hEE);
    chk("fullrw_out", 32'(buf_out), 32'(exp_d));
    chk("fullrw_cnt", 32'(fifo_cnt), 7);
    for (int i = 0; i < 7; i++) begin
      exp_d = q.pop_front();
      step(0, 1, 8'h00);
      chk("fullrw_drain", 32'(buf_out), 32'(exp_d));
    end
    chk("fullrw_empty", 32'(empty), 1);
    step(1, 1, 8'h5A);
    chk("emptyrw_cnt", 32'(fifo_cnt), 1);
    chk("emptyrw_out", 32'(buf_out), 32'(exp_d));
    step(0, 1, 8'h00);
    chk("emptyrw_rd", 32'(buf_out), 32'h5A);
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h11 + i));
    chk("pre_arst_cnt", 32'(fifo_cnt), 5);
    #3 rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(fifo_cnt), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_out", 32'(buf_out), 0);
    #1 rst = 1'b0;
    step(1, 0, 8'h77);
    step(1, 0, 8'h78);
    chk("post_arst_cnt", 32'(fifo_cnt), 2);
    step(0, 1, 8'h00);
    chk("post_arst_out", 32'(buf_out), 32'h77);
    step(0, 1, 8'h00);
    chk("post_arst_out2", 32'(buf_out), 32'h78);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
